// File: rtl/plab3_mem_tz_mem_filter.sv
// Secure-window filter between blocking L1 cache and memory; refused requests get a local response.
// Latency: forwarded accept->cacheresp_val 3 cycles, refused accept->cacheresp_val 1 cycle.
// Backpressure: one request outstanding; cachereq_rdy low until the cache response handshake completes.
module plab3_mem_tz_mem_filter #(
    parameter int unsigned p_opaque_nbits = 8,
    parameter int unsigned p_addr_nbits   = 32,
    parameter int unsigned p_data_nbits   = 128,
    parameter logic [p_addr_nbits-1:0] p_sec_base = 32'h0000_8000,
    parameter logic [p_addr_nbits-1:0] p_sec_size = 32'h0000_1000,
    parameter int unsigned p_cnt_nbits    = 8,
    localparam int unsigned c_len_nbits   = $clog2(p_data_nbits / 8),
    localparam int unsigned c_req_nbits   = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits + p_data_nbits,
    localparam int unsigned c_resp_nbits  = 3 + p_opaque_nbits + c_len_nbits + p_data_nbits
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cachereq_val,
    output logic                     cachereq_rdy,
    input  logic [c_req_nbits-1:0]   cachereq_msg,
    input  logic                     cachereq_domain,
    output logic                     cacheresp_val,
    input  logic                     cacheresp_rdy,
    output logic [c_resp_nbits-1:0]  cacheresp_msg,
    output logic                     cacheresp_domain,
    output logic                     memreq_val,
    input  logic                     memreq_rdy,
    output logic [c_req_nbits-1:0]   memreq_msg,
    output logic                     memreq_domain,
    input  logic                     memresp_val,
    output logic                     memresp_rdy,
    input  logic [c_resp_nbits-1:0]  memresp_msg,
    input  logic                     memresp_domain,
    input  logic                     viol_clear,
    output logic                     viol_flag,
    output logic [p_cnt_nbits-1:0]   viol_count,
    output logic [p_addr_nbits-1:0]  viol_addr
);

    localparam int unsigned c_addr_lsb = p_data_nbits + c_len_nbits;
    localparam int unsigned c_op_lsb   = c_addr_lsb + p_addr_nbits;
    localparam int unsigned c_type_lsb = c_op_lsb + p_opaque_nbits;

    // One extra bit so base+size never wraps at the top of the address space.
    localparam logic [p_addr_nbits:0] c_win_lo = {1'b0, p_sec_base};
    localparam logic [p_addr_nbits:0] c_win_hi = {1'b0, p_sec_base} + {1'b0, p_sec_size};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_WAIT,
        S_RESP,
        S_LOCAL
    } state_t;

    state_t                     state_q, state_d;
    logic [c_req_nbits-1:0]     req_msg_q, req_msg_d;
    logic                       req_dom_q, req_dom_d;
    logic [c_resp_nbits-1:0]    resp_msg_q, resp_msg_d;
    logic                       resp_dom_q, resp_dom_d;
    logic                       viol_flag_q, viol_flag_d;
    logic [p_cnt_nbits-1:0]     viol_count_q, viol_count_d;
    logic [p_addr_nbits-1:0]    viol_addr_q, viol_addr_d;

    logic [p_addr_nbits-1:0]    req_addr;
    logic                       win_hit;
    logic                       req_viol;
    logic [c_resp_nbits-1:0]    local_msg;

    assign req_addr = cachereq_msg[c_addr_lsb +: p_addr_nbits];
    assign win_hit  = ({1'b0, req_addr} >= c_win_lo) && ({1'b0, req_addr} < c_win_hi);
    assign req_viol = (state_q == S_IDLE) && cachereq_val && cachereq_domain && win_hit;

    // Refusal echoes type and opaque so the cache can match it; length and data are zero.
    assign local_msg = {req_msg_q[c_type_lsb +: 3], req_msg_q[c_op_lsb +: p_opaque_nbits],
                        {(c_len_nbits + p_data_nbits){1'b0}}};

    always_comb begin
        state_d    = state_q;
        req_msg_d  = req_msg_q;
        req_dom_d  = req_dom_q;
        resp_msg_d = resp_msg_q;
        resp_dom_d = resp_dom_q;
        unique case (state_q)
            S_IDLE: begin
                if (cachereq_val) begin
                    req_msg_d = cachereq_msg;
                    req_dom_d = cachereq_domain;
                    state_d   = (cachereq_domain && win_hit) ? S_LOCAL : S_FWD;
                end
            end
            S_FWD: begin
                if (memreq_rdy) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (memresp_val) begin
                    resp_msg_d = memresp_msg;
                    resp_dom_d = memresp_domain;
                    state_d    = S_RESP;
                end
            end
            S_RESP, S_LOCAL: begin
                if (cacheresp_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        viol_flag_d  = viol_flag_q;
        viol_count_d = viol_count_q;
        viol_addr_d  = viol_addr_q;
        // A violation arriving with a clear counts as the first event after the clear.
        if (req_viol) begin
            viol_flag_d = 1'b1;
            viol_addr_d = req_addr;
            if (viol_clear)
                viol_count_d = p_cnt_nbits'(1);
            else if (!(&viol_count_q))
                viol_count_d = viol_count_q + p_cnt_nbits'(1);
        end else if (viol_clear) begin
            viol_flag_d  = 1'b0;
            viol_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            req_msg_q    <= '0;
            req_dom_q    <= 1'b0;
            resp_msg_q   <= '0;
            resp_dom_q   <= 1'b0;
            viol_flag_q  <= 1'b0;
            viol_count_q <= '0;
            viol_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_msg_q    <= req_msg_d;
            req_dom_q    <= req_dom_d;
            resp_msg_q   <= resp_msg_d;
            resp_dom_q   <= resp_dom_d;
            viol_flag_q  <= viol_flag_d;
            viol_count_q <= viol_count_d;
            viol_addr_q  <= viol_addr_d;
        end
    end

    assign cachereq_rdy     = (state_q == S_IDLE);
    assign memreq_val       = (state_q == S_FWD);
    assign memreq_msg       = req_msg_q;
    assign memreq_domain    = req_dom_q;
    assign memresp_rdy      = (state_q == S_WAIT);
    assign cacheresp_val    = (state_q == S_RESP) || (state_q == S_LOCAL);
    assign cacheresp_msg    = (state_q == S_LOCAL) ? local_msg : resp_msg_q;
    assign cacheresp_domain = (state_q == S_LOCAL) ? 1'b1 : resp_dom_q;
    assign viol_flag        = viol_flag_q;
    assign viol_count       = viol_count_q;
    assign viol_addr        = viol_addr_q;

endmodule

// File: tb/tb_plab3_mem_tz_mem_filter.sv
// Bench for plab3_mem_tz_mem_filter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_plab3_mem_tz_mem_filter;

    localparam int REQ_W  = 175;
    localparam int RESP_W = 143;
    localparam longint SEC_BASE = 64'h8000;
    localparam longint SEC_SIZE = 64'h1000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cachereq_val = 1'b0;
    logic              cachereq_rdy;
    logic [REQ_W-1:0]  cachereq_msg = '0;
    logic              cachereq_domain = 1'b0;
    logic              cacheresp_val;
    logic              cacheresp_rdy = 1'b0;
    logic [RESP_W-1:0] cacheresp_msg;
    logic              cacheresp_domain;
    logic              memreq_val;
    logic              memreq_rdy = 1'b0;
    logic [REQ_W-1:0]  memreq_msg;
    logic              memreq_domain;
    logic              memresp_val = 1'b0;
    logic              memresp_rdy;
    logic [RESP_W-1:0] memresp_msg = '0;
    logic              memresp_domain = 1'b0;
    logic              viol_clear = 1'b0;
    logic              viol_flag;
    logic [7:0]        viol_count;
    logic [31:0]       viol_addr;

    always #5 clk = ~clk;

    plab3_mem_tz_mem_filter dut (
        .clk(clk), .reset(reset),
        .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy),
        .cachereq_msg(cachereq_msg), .cachereq_domain(cachereq_domain),
        .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy),
        .cacheresp_msg(cacheresp_msg), .cacheresp_domain(cacheresp_domain),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memreq_msg(memreq_msg), .memreq_domain(memreq_domain),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .memresp_msg(memresp_msg), .memresp_domain(memresp_domain),
        .viol_clear(viol_clear), .viol_flag(viol_flag),
        .viol_count(viol_count), .viol_addr(viol_addr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: where the single outstanding transaction currently sits.
    bit                m_fwd, m_wait, m_resp;
    logic [REQ_W-1:0]  m_req;
    logic              m_req_dom;
    logic [RESP_W-1:0] m_rsp;
    logic              m_rsp_dom;
    bit                m_flag;
    int                m_cnt;
    logic [31:0]       m_addr;

    int                n_mreq_hs = 0, n_resp_hs = 0, t_acc = 0, t_mreq = 0, t_resp = 0;
    logic [REQ_W-1:0]  last_mreq;
    logic [RESP_W-1:0] last_rsp;
    logic              last_rsp_dom;

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] mk_req(logic [2:0] ty, logic [7:0] op, logic [31:0] a, logic [127:0] d);
        return {ty, op, a, 4'h0, d};
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 32'h7FF0;
            1: return 32'h8000;
            2: return 32'h8FF0;
            3: return 32'h9000;
            4: return 32'h8FFF;
            5: return 32'h7FFF;
            6: return 32'h8000 + (32'($urandom_range(0, 255)) << 4);
            default: return $urandom();
        endcase
    endfunction

    task automatic model_clear();
        m_fwd = 0; m_wait = 0; m_resp = 0;
        m_flag = 0; m_cnt = 0; m_addr = '0;
    endtask

    task automatic check_outputs();
        bit busy;
        busy = m_fwd || m_wait || m_resp;
        chk("cachereq_rdy", cachereq_rdy, !busy);
        chk("memreq_val", memreq_val, m_fwd);
        if (m_fwd) begin
            chk("memreq_msg", memreq_msg, m_req);
            chk("memreq_domain", memreq_domain, m_req_dom);
        end
        chk("memresp_rdy", memresp_rdy, m_wait);
        chk("cacheresp_val", cacheresp_val, m_resp);
        if (m_resp) begin
            chk("cacheresp_msg", cacheresp_msg, m_rsp);
            chk("cacheresp_domain", cacheresp_domain, m_rsp_dom);
        end
        chk("viol_flag", viol_flag, m_flag);
        chk("viol_count", viol_count, m_cnt);
        chk("viol_addr", viol_addr, m_addr);
    endtask

    // Advance the model by what the next clock edge does with the inputs now driven.
    task automatic model_update();
        bit busy;
        bit viol_acc;
        logic [31:0] a;
        busy = m_fwd || m_wait || m_resp;
        viol_acc = 0;
        if (!busy) begin
            if (cachereq_val) begin
                a = cachereq_msg[163:132];
                t_acc = cyc;
                if (cachereq_domain && longint'(a) >= SEC_BASE && longint'(a) < SEC_BASE + SEC_SIZE) begin
                    viol_acc = 1;
                    m_resp = 1;
                    m_rsp = {cachereq_msg[174:172], cachereq_msg[171:164], 132'b0};
                    m_rsp_dom = 1'b1;
                    m_flag = 1;
                    m_addr = a;
                    m_cnt = viol_clear ? 1 : (m_cnt >= 255 ? 255 : m_cnt + 1);
                end else begin
                    m_fwd = 1;
                    m_req = cachereq_msg;
                    m_req_dom = cachereq_domain;
                end
            end
        end else if (m_fwd) begin
            if (memreq_rdy) begin
                m_fwd = 0; m_wait = 1;
                n_mreq_hs++; t_mreq = cyc; last_mreq = memreq_msg;
            end
        end else if (m_wait) begin
            if (memresp_val) begin
                m_wait = 0; m_resp = 1;
                m_rsp = memresp_msg; m_rsp_dom = memresp_domain;
            end
        end else if (cacheresp_rdy) begin
            m_resp = 0;
            n_resp_hs++; t_resp = cyc;
            last_rsp = cacheresp_msg; last_rsp_dom = cacheresp_domain;
        end
        if (!viol_acc && viol_clear) begin
            m_flag = 0; m_cnt = 0;
        end
    endtask

    task automatic cycle();
        check_outputs();
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int g = 0; g < 100 && (m_fwd || m_wait || m_resp); g++) cycle();
    endtask

    task automatic txn(logic [REQ_W-1:0] msg, logic dom, logic clr);
        drain();
        cachereq_msg = msg; cachereq_domain = dom; cachereq_val = 1'b1; viol_clear = clr;
        cycle();
        cachereq_val = 1'b0; viol_clear = 1'b0;
        drain();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_memreq_val", memreq_val, 1'b0);
        chk("rst_memresp_rdy", memresp_rdy, 1'b0);
        chk("rst_cacheresp_val", cacheresp_val, 1'b0);
        chk("rst_viol_flag", viol_flag, 1'b0);
        chk("rst_viol_count", viol_count, 8'h00);
        chk("rst_viol_addr", viol_addr, 32'h0);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_cachereq_rdy", cachereq_rdy, 1'b1);
    endtask

    int n0;
    int ta;

    initial begin
        model_clear();
        #2;
        do_reset();

        // Reset while waiting on a stalled memory.
        memreq_rdy = 1'b1; memresp_val = 1'b0; cacheresp_rdy = 1'b1;
        cachereq_msg = mk_req(3'd0, 8'h01, 32'h100, '0); cachereq_domain = 1'b0; cachereq_val = 1'b1;
        cycle();
        cachereq_val = 1'b0;
        cycle();
        cycle();
        chk("t1_in_wait", memresp_rdy, 1'b1);
        do_reset();
        memresp_val = 1'b1;
        cycle();
        memresp_val = 1'b0;
        cycle();

        // Secure read forwarded with minimum latency.
        memresp_val = 1'b1; memresp_domain = 1'b0;
        memresp_msg = {3'd0, 8'h11, 4'h0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF};
        txn(mk_req(3'd0, 8'h11, 32'h8040, '0), 1'b0, 1'b0);
        chk("t2_memreq_addr", last_mreq[163:132], 32'h8040);
        chk("t2_memreq_lat", t_mreq - t_acc, 1);
        chk("t2_resp_lat", t_resp - t_acc, 3);
        chk("t2_resp_data", last_rsp[127:0], 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF);
        chk("t2_resp_dom", last_rsp_dom, 1'b0);
        chk("t2_viol_count", viol_count, 8'h00);

        // Non-secure write into the window is refused locally.
        n0 = n_mreq_hs;
        txn(mk_req(3'd1, 8'hA7, 32'h8FF0, 128'h1234), 1'b1, 1'b0);
        chk("t3_no_memreq", n_mreq_hs, n0);
        chk("t3_resp_type", last_rsp[142:140], 3'd1);
        chk("t3_resp_opaque", last_rsp[139:132], 8'hA7);
        chk("t3_resp_lendata", last_rsp[131:0], 132'h0);
        chk("t3_resp_dom", last_rsp_dom, 1'b1);
        chk("t3_resp_lat", t_resp - t_acc, 1);
        chk("t3_viol_flag", viol_flag, 1'b1);
        chk("t3_viol_count", viol_count, 8'd1);
        chk("t3_viol_addr", viol_addr, 32'h8FF0);

        // Window edges from the non-secure domain.
        n0 = n_mreq_hs;
        txn(mk_req(3'd0, 8'h21, 32'h7FF0, '0), 1'b1, 1'b0);
        txn(mk_req(3'd0, 8'h22, 32'h9000, '0), 1'b1, 1'b0);
        txn(mk_req(3'd0, 8'h23, 32'h8000, '0), 1'b1, 1'b0);
        chk("t4_fwd_count", n_mreq_hs, n0 + 2);
        chk("t4_viol_count", viol_count, 8'd2);
        chk("t4_viol_addr", viol_addr, 32'h8000);

        // Saturation, then clear coinciding with a violation, then clear alone.
        for (int i = 0; i < 256; i++)
            txn(mk_req(3'd0, 8'(i), 32'h8000 + 32'(i * 16), '0), 1'b1, 1'b0);
        chk("t5_saturated", viol_count, 8'hFF);
        txn(mk_req(3'd0, 8'h55, 32'h8120, '0), 1'b1, 1'b1);
        chk("t5_clr_viol_count", viol_count, 8'd1);
        chk("t5_clr_viol_flag", viol_flag, 1'b1);
        chk("t5_clr_viol_addr", viol_addr, 32'h8120);
        viol_clear = 1'b1;
        cycle();
        viol_clear = 1'b0;
        cycle();
        chk("t5_clear_count", viol_count, 8'd0);
        chk("t5_clear_flag", viol_flag, 1'b0);
        chk("t5_clear_addr_held", viol_addr, 32'h8120);

        // Back-pressure on both sides with a second request waiting.
        memreq_rdy = 1'b0; memresp_val = 1'b0; cacheresp_rdy = 1'b0;
        cachereq_msg = mk_req(3'd1, 8'h66, 32'h200, 128'hCAFE); cachereq_domain = 1'b0; cachereq_val = 1'b1;
        cycle();
        ta = t_acc;
        cachereq_msg = mk_req(3'd0, 8'h77, 32'h300, '0);
        for (int i = 0; i < 5; i++) cycle();
        memreq_rdy = 1'b1;
        cycle();
        memreq_rdy = 1'b0; memresp_val = 1'b1; memresp_msg = {3'd1, 8'h66, 4'h0, 128'h0}; memresp_domain = 1'b0;
        cycle();
        memresp_val = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        cacheresp_rdy = 1'b1;
        cycle();
        chk("t6_resp_lat", t_resp - ta, 11);
        chk("t6_second_pending", cachereq_rdy, 1'b1);
        cycle();
        cachereq_val = 1'b0;
        chk("t6_second_accept", t_acc - ta, 12);
        memreq_rdy = 1'b1; memresp_val = 1'b1;
        drain();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            cachereq_val = ($urandom_range(0, 1) == 1);
            cachereq_domain = ($urandom_range(0, 1) == 1);
            cachereq_msg = mk_req(3'($urandom_range(0, 1)), 8'($urandom()), pick_addr(),
                                  {$urandom(), $urandom(), $urandom(), $urandom()});
            memreq_rdy = ($urandom_range(0, 9) < 6);
            memresp_val = ($urandom_range(0, 1) == 1);
            memresp_domain = ($urandom_range(0, 1) == 1);
            memresp_msg = {3'($urandom_range(0, 1)), 8'($urandom()), 4'($urandom()),
                           $urandom(), $urandom(), $urandom(), $urandom()};
            cacheresp_rdy = ($urandom_range(0, 9) < 6);
            viol_clear = ($urandom_range(0, 39) == 0);
            cycle();
        end
        cachereq_val = 1'b0; viol_clear = 1'b0;
        memreq_rdy = 1'b1; memresp_val = 1'b1; cacheresp_rdy = 1'b1;
        drain();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
